// File: rtl/up_cnt_ctrl.sv
// up_cnt_ctrl: programmable timer built around an up-counter.
// A prescaler divides RUN cycles into ticks; each tick advances the count
// until it matches the latched terminal value, at which point a one-cycle
// done pulse is produced and the timer either stops (one-shot) or reloads
// to zero (auto-reload). Configuration is captured on start so the upstream
// inputs may change freely while the timer runs.
module up_cnt_ctrl #(
    parameter int WIDTH = 4,
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] terminal,
    input  logic [PSC_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    // Encoding is visible on the debug state port, so it is fixed explicitly.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_PAUSED = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [PSC_W-1:0]   psc_cnt_q, psc_cnt_d;
    logic [WIDTH-1:0]   term_q, term_d;
    logic [PSC_W-1:0]   psc_q, psc_d;
    logic               mode_q, mode_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    // Tick and terminal-match decodes on the latched configuration.
    logic tick;
    logic at_term;

    assign tick    = (psc_cnt_q == psc_q);
    assign at_term = (count_q == term_q);

    // Next-state and datapath decode; priority is stop, then start, then pause.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        psc_cnt_d = psc_cnt_q;
        term_d    = term_q;
        psc_d     = psc_q;
        mode_d    = mode_q;
        done_d    = 1'b0;

        if (stop) begin
            // Abort: everything returns to a clean idle with a zero count.
            state_d   = S_IDLE;
            count_d   = '0;
            psc_cnt_d = '0;
        end else if (start) begin
            // Start or restart from any state; a restart never emits done.
            state_d   = S_RUN;
            term_d    = terminal;
            psc_d     = prescale;
            mode_d    = mode;
            count_d   = '0;
            psc_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Count keeps whatever value the last run left behind.
                    state_d = S_IDLE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                S_RUN, S_PAUSED: begin
                    if (pause) begin
                        // Frozen: count and prescaler keep their values.
                        state_d = S_PAUSED;
                    end else begin
                        // An unpaused cycle in PAUSED resumes counting at once,
                        // so the delay added by a pause equals its length.
                        state_d = S_RUN;
                        if (tick) begin
                            psc_cnt_d = '0;
                            if (at_term) begin
                                done_d = 1'b1;
                                if (mode_q) begin
                                    count_d = '0;
                                end else begin
                                    state_d = S_DONE;
                                end
                            end else begin
                                count_d = count_q + WIDTH'(1);
                            end
                        end else begin
                            psc_cnt_d = psc_cnt_q + PSC_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, prescaler, latched configuration and registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            psc_cnt_q <= '0;
            term_q    <= '0;
            psc_q     <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            psc_cnt_q <= psc_cnt_d;
            term_q    <= term_d;
            psc_q     <= psc_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_up_cnt_ctrl.sv
// Testbench for up_cnt_ctrl: directed scenarios with fixed expectations,
// then randomized traffic compared against an arithmetic reference model
// that derives count/done from the number of unpaused run cycles since start.
module tb_up_cnt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] terminal = 4'd0;
    logic [3:0] prescale = 4'd0;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    up_cnt_ctrl #(.WIDTH(4), .PSC_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .terminal(terminal), .prescale(prescale),
        .count(count), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: a running timer is described by how many unpaused
    // run cycles have elapsed since start; count = ticks mod (term+1).
    bit m_active;   // RUN or PAUSED
    bit m_paused;
    bit m_done_st;  // one-cycle DONE state
    bit m_done;
    int m_units;
    int m_hold;     // count shown while not active
    int m_term, m_psc, m_mode;

    task automatic model_step();
        int cyc;
        if (rst) begin
            m_active = 0; m_paused = 0; m_done_st = 0; m_done = 0;
            m_units = 0; m_hold = 0; m_term = 0; m_psc = 0; m_mode = 0;
        end else if (stop) begin
            m_active = 0; m_paused = 0; m_done_st = 0; m_done = 0; m_hold = 0;
        end else if (start) begin
            m_term = terminal; m_psc = prescale; m_mode = mode;
            m_active = 1; m_paused = 0; m_done_st = 0; m_done = 0; m_units = 0;
        end else if (m_done_st) begin
            m_done_st = 0; m_done = 0;
        end else if (m_active) begin
            m_done = 0;
            if (pause) begin
                m_paused = 1;
            end else begin
                m_paused = 0;
                m_units++;
                cyc = (m_term + 1) * (m_psc + 1);
                if (m_units % cyc == 0) begin
                    m_done = 1;
                    if (m_mode == 0) begin
                        m_active = 0; m_done_st = 1; m_hold = m_term;
                    end
                end
            end
        end else begin
            m_done = 0;
        end
    endtask

    function automatic int model_count();
        if (m_active) return (m_units / (m_psc + 1)) % (m_term + 1);
        return m_hold;
    endfunction

    function automatic int model_state();
        if (m_done_st) return 3;
        if (m_active && m_paused) return 2;
        if (m_active) return 1;
        return 0;
    endfunction

    // One clock: inputs already stable, model follows the edge, sample 1ns later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_start(input int t, input int p, input bit md);
        terminal = 4'(t); prescale = 4'(p); mode = md; start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; terminal = 4'd7;
        cycle(); cycle();
        rst = 1'b0; start = 1'b0;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        $display("test_reset: state=%0d count=%0d busy=%0b done=%0b", state, count, busy, done);
    endtask

    task automatic test_oneshot();
        do_start(5, 0, 1'b0);
        checks++; if (count !== 4'd0 || state !== 2'd1 || busy !== 1'b1) begin
            failures++; $display("FAIL oneshot_entry count=%0d state=%0d busy=%0b exp=0/1/1", count, state, busy); end
        for (int k = 1; k <= 5; k++) begin
            cycle();
            checks++; if (count !== 4'(k) || done !== 1'b0) begin
                failures++; $display("FAIL oneshot_step k=%0d count=%0d done=%0b exp=%0d/0", k, count, done, k); end
        end
        cycle();
        checks++; if (done !== 1'b1 || state !== 2'd3 || count !== 4'd5) begin
            failures++; $display("FAIL oneshot_done done=%0b state=%0d count=%0d exp=1/3/5", done, state, count); end
        cycle();
        checks++; if (done !== 1'b0 || state !== 2'd0 || count !== 4'd5 || busy !== 1'b0) begin
            failures++; $display("FAIL oneshot_idle done=%0b state=%0d count=%0d busy=%0b exp=0/0/5/0", done, state, count, busy); end
        $display("test_oneshot: final state=%0d count=%0d", state, count);
    endtask

    task automatic test_autoreload();
        do_start(3, 2, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            cycle();
            checks++; if (count !== 4'((k / 3) % 4) || done !== (k % 12 == 0) || busy !== 1'b1) begin
                failures++; $display("FAIL reload_step k=%0d count=%0d done=%0b busy=%0b exp=%0d/%0b/1",
                                     k, count, done, busy, (k / 3) % 4, (k % 12 == 0)); end
        end
        $display("test_autoreload: count=%0d busy=%0b", count, busy);
    endtask

    task automatic test_pause();
        do_start(9, 0, 1'b0);
        for (int k = 1; k <= 4; k++) cycle();
        checks++; if (count !== 4'd4) begin failures++; $display("FAIL pause_pre count=%0d exp=4", count); end
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++; if (state !== 2'd2 || count !== 4'd4 || busy !== 1'b1) begin
                failures++; $display("FAIL pause_hold k=%0d state=%0d count=%0d busy=%0b exp=2/4/1", k, state, count, busy); end
        end
        pause = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            cycle();
            checks++; if (count !== 4'(4 + j) || done !== 1'b0) begin
                failures++; $display("FAIL pause_resume j=%0d count=%0d done=%0b exp=%0d/0", j, count, done, 4 + j); end
        end
        cycle();
        checks++; if (done !== 1'b1 || state !== 2'd3 || count !== 4'd9) begin
            failures++; $display("FAIL pause_done done=%0b state=%0d count=%0d exp=1/3/9", done, state, count); end
        cycle();
        $display("test_pause: done arrived 14 cycles after start");
    endtask

    task automatic test_stop_and_rst();
        do_start(10, 0, 1'b0);
        for (int k = 1; k <= 6; k++) cycle();
        checks++; if (count !== 4'd6) begin failures++; $display("FAIL stop_pre count=%0d exp=6", count); end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        checks++; if (state !== 2'd0 || count !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL stop_idle state=%0d count=%0d done=%0b busy=%0b exp=0/0/0/0", state, count, done, busy); end
        for (int k = 0; k < 12; k++) begin
            cycle();
            checks++; if (done !== 1'b0 || count !== 4'd0) begin
                failures++; $display("FAIL stop_quiet k=%0d done=%0b count=%0d exp=0/0", k, done, count); end
        end
        do_start(8, 0, 1'b1);
        cycle(); cycle();
        rst = 1'b1; start = 1'b1; terminal = 4'd3;
        cycle();
        rst = 1'b0; start = 1'b0;
        checks++; if (state !== 2'd0 || count !== 4'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_wins state=%0d count=%0d busy=%0b exp=0/0/0", state, count, busy); end
        cycle();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_after state=%0d exp=0", state); end
        $display("test_stop_and_rst: state=%0d count=%0d", state, count);
    endtask

    task automatic test_term_zero_restart();
        do_start(0, 0, 1'b0);
        checks++; if (count !== 4'd0 || state !== 2'd1 || done !== 1'b0) begin
            failures++; $display("FAIL tz_entry count=%0d state=%0d done=%0b exp=0/1/0", count, state, done); end
        cycle();
        checks++; if (done !== 1'b1 || state !== 2'd3 || count !== 4'd0) begin
            failures++; $display("FAIL tz_done done=%0b state=%0d count=%0d exp=1/3/0", done, state, count); end
        cycle();
        do_start(7, 1, 1'b1);
        for (int k = 1; k <= 5; k++) cycle();
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL restart_pre count=%0d exp=2", count); end
        do_start(2, 0, 1'b1);
        checks++; if (count !== 4'd0 || state !== 2'd1 || done !== 1'b0) begin
            failures++; $display("FAIL restart_entry count=%0d state=%0d done=%0b exp=0/1/0", count, state, done); end
        for (int k = 1; k <= 6; k++) begin
            cycle();
            checks++; if (count !== 4'(k % 3) || done !== (k % 3 == 0)) begin
                failures++; $display("FAIL restart_step k=%0d count=%0d done=%0b exp=%0d/%0b", k, count, done, k % 3, (k % 3 == 0)); end
        end
        $display("test_term_zero_restart: count=%0d state=%0d", count, state);
    endtask

    task automatic test_term_max();
        do_start(15, 1, 1'b1);
        for (int k = 1; k <= 70; k++) begin
            cycle();
            checks++; if (count !== 4'((k / 2) % 16) || done !== (k % 32 == 0)) begin
                failures++; $display("FAIL tmax_step k=%0d count=%0d done=%0b exp=%0d/%0b", k, count, done, (k / 2) % 16, (k % 32 == 0)); end
        end
        stop = 1'b1; cycle(); stop = 1'b0;
        $display("test_term_max: 70 cycles at terminal 15");
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            start    = ($urandom_range(0, 24) == 0);
            pause    = ($urandom_range(0, 3) == 0);
            mode     = 1'($urandom_range(0, 1));
            terminal = 4'($urandom_range(0, 15));
            prescale = 4'($urandom_range(0, 3));
            cycle();
            checks++; if (count !== 4'(model_count()) || state !== 2'(model_state()) ||
                          busy !== m_active || done !== m_done) begin
                failures++; $display("FAIL random n=%0d count=%0d state=%0d busy=%0b done=%0b exp=%0d/%0d/%0b/%0b",
                                     n, count, state, busy, done, model_count(), model_state(), m_active, m_done); end
            $display("rand n=%0d rst=%0b stop=%0b start=%0b pause=%0b count=%0d state=%0d done=%0b",
                     n, rst, stop, start, pause, count, state, done);
        end
        rst = 1'b0; stop = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_pause();
        test_stop_and_rst();
        test_term_zero_restart();
        test_term_max();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/up_cnt_ctrl.md
Name: up_cnt_ctrl

Overview:
Sequencing controller wrapped around an up-counter datapath. It turns a free-running up-counter into a programmable timer with the following features:
- start, stop and pause controls
- a prescaler
- a programmable terminal count
- one-shot or auto-reload modes

Upstream logic uses it as a timing/event source. The one-cycle done pulse drives downstream sequencers.

Parameters:
- WIDTH, 4, width of the count and terminal values.
- PSC_W, 4, width of the prescale value.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; latches config, clears count, enters RUN.
- stop  in  1  pulse; abort to IDLE, count cleared.
- pause  in  1  level; while high in RUN/PAUSED, the counter is frozen.
- mode  in  1  0 = one-shot, 1 = auto-reload; sampled on start.
- terminal  in  WIDTH  terminal count; sampled on start.
- prescale  in  PSC_W  tick divider: count advances every prescale+1 unpaused RUN cycles; sampled on start.
- count  out  WIDTH  current count value (registered).
- busy  out  1  high in RUN or PAUSED.
- done  out  1  one-cycle pulse when count advances while equal to terminal.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 DONE (debug).

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, count=0, busy=0, done=0.
  - prescaler=0; latched term/psc/mode=0.
  - rst overrides all other inputs.
- Input priority per cycle: rst > stop > start > pause.
- IDLE:
  - start=1 -> RUN next cycle; latch terminal, prescale and mode; count=0; prescaler=0.
  - All other inputs are ignored.
- RUN:
  - pause=1 -> PAUSED next cycle; count and prescaler hold.
  - Otherwise the prescaler increments each cycle.
  - When prescaler==psc_latched, a tick occurs: prescaler returns to 0.
  - On a tick with count != term_latched: count increments by 1.
  - On a tick with count == term_latched:
    - done=1 for exactly that cycle's following register update (a one-cycle pulse).
    - mode=0: go to DONE; count holds at terminal.
    - mode=1: count=0, stay RUN, prescaler continues from 0.
- PAUSED:
  - pause=0 -> RUN; count and prescaler resume from their held values.
  - No ticks occur while paused.
- DONE:
  - Unconditionally -> IDLE after one cycle; count holds at terminal value.
  - Count stays held in IDLE until the next start.
- stop=1 in any non-reset state: next cycle state=IDLE, count=0, prescaler=0, done=0.
- start=1 in RUN/PAUSED/DONE: restart. Re-latch config, count=0, prescaler=0, state=RUN. No done is produced by the restart.
- Arithmetic and boundaries:
  - count is unsigned WIDTH bits.
  - terminal=0 -> done on the first tick, i.e. prescale+1 cycles after entering RUN.
  - terminal=2^WIDTH-1 -> done on the tick at count 15, then either reload to 0 or hold; there is no natural wrap beyond terminal.
  - prescale=0 -> a tick every RUN cycle.
- Latency:
  - done asserts in the cycle after the tick edge where count==terminal.
  - From the start pulse edge, one-shot done occurs (terminal+1)*(prescale+1) cycles later.
- busy is registered; it equals 1 exactly when state is RUN or PAUSED.

Test Plan:
- Reset, then start with terminal=5, prescale=0, mode=0 -> count steps 0,1,2,3,4,5 on consecutive cycles; done pulses once 6 cycles after start; state DONE then IDLE; count holds 5; busy falls.
- Start with terminal=3, prescale=2, mode=1; run 30 cycles -> count advances every 3 cycles, 0..3 then back to 0; done pulses every 12 cycles; busy stays 1.
- terminal=9, prescale=0, one-shot; assert pause for 4 cycles at count=4 -> state PAUSED; count frozen at 4; done arrives 4 cycles later than in the unpaused run.
- Mid-run stop at count=6 (terminal=10) -> next cycle IDLE, count=0, no done. Then a start in the same cycle as rst=1 -> rst wins: IDLE, count=0.
- terminal=0, prescale=0, mode=0 -> done on the first cycle after RUN entry; count stays 0. Then a restart with start while RUN in auto-reload mode -> count returns to 0 and the new config is applied.
- terminal=15, prescale=1, mode=1 -> count reaches 15, reloads to 0; done pulses every 32 cycles; count never exceeds 15.
